ldo_adaptive_ctrl: RTL and testbench

LDO_ADAPTIVE_CTRL -- requirements
Module: ldo_adaptive_ctrl

---
 rtl/ldo_adaptive_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ldo_adaptive_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ldo_adaptive_ctrl.sv
// Digital LDO loop controller: coarse/fine/locked search over a thermometer of pass devices.
// Comparator decision is registered once; gate, count and status flags are all registered.
module ldo_adaptive_ctrl #(
  parameter int unsigned N_CELLS     = 32,
  parameter int unsigned COARSE_STEP = 4,
  parameter int unsigned LOCK_DIV    = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_en,
  input  logic                           i_comp_in,
  input  logic                           i_test_en,
  input  logic [N_CELLS-1:0]             i_test_code,
  output logic [N_CELLS-1:0]             o_gate,
  output logic [$clog2(N_CELLS+1)-1:0]   o_count,
  output logic                           o_locked,
  output logic                           o_sat_hi,
  output logic                           o_sat_lo
);

  localparam int unsigned CW = $clog2(N_CELLS + 1);
  localparam int unsigned DW = $clog2(LOCK_DIV);
  localparam logic [CW-1:0] MaxCnt = CW'(N_CELLS);
  localparam logic [CW-1:0] CStep  = CW'(COARSE_STEP);
  localparam logic [CW-1:0] FStep  = CW'(1);
  localparam logic [DW-1:0] DivMax = DW'(LOCK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StCoarse, StFine, StLocked} state_e;

  state_e              r_state, w_state_d;
  logic [CW-1:0]       r_count, w_count_d;
  logic [N_CELLS-1:0]  r_gate, w_gate_d, w_therm;
  logic [DW-1:0]       r_div_cnt, w_div_cnt_d;
  logic [2:0]          r_alt_cnt, w_alt_cnt_d;
  logic [2:0]          r_same_cnt, w_same_cnt_d;
  logic                r_comp_q;
  logic                r_comp_vld, w_comp_vld_d;
  logic                r_prev_dir, w_prev_dir_d;
  logic                r_prev_vld, w_prev_vld_d;
  logic                r_locked, r_sat_hi, r_sat_lo;
  logic                w_dir, w_rev;
  logic [2:0]          w_alt_inc, w_same_inc;

  function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] cnt,
                                              input logic [CW-1:0] step,
                                              input logic          up);
    logic [CW-1:0] room;
    room = MaxCnt - cnt;
    if (up) return (step >= room) ? MaxCnt : cnt + step;
    return (step >= cnt) ? '0 : cnt - step;
  endfunction

  assign w_dir      = r_comp_q;
  assign w_rev      = r_prev_vld && (w_dir != r_prev_dir);
  assign w_alt_inc  = r_alt_cnt + 3'd1;
  assign w_same_inc = r_same_cnt + 3'd1;

  always_comb begin
    w_state_d    = r_state;
    w_count_d    = r_count;
    w_div_cnt_d  = r_div_cnt;
    w_alt_cnt_d  = r_alt_cnt;
    w_same_cnt_d = r_same_cnt;
    w_prev_dir_d = r_prev_dir;
    w_prev_vld_d = r_prev_vld;
    // The sample captured on the enabling edge is discarded while the comparator settles.
    w_comp_vld_d = i_en && (r_state != StIdle);

    if (!i_en) begin
      w_state_d    = StIdle;
      w_div_cnt_d  = '0;
      w_alt_cnt_d  = '0;
      w_same_cnt_d = '0;
      w_prev_vld_d = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_d    = StCoarse;
          w_prev_vld_d = 1'b0;
        end
        StCoarse: begin
          if (r_comp_vld) begin
            w_prev_dir_d = w_dir;
            w_prev_vld_d = 1'b1;
            if (w_rev) begin
              w_state_d    = StFine;
              w_count_d    = sat_step(r_count, FStep, w_dir);
              w_alt_cnt_d  = 3'd1;
              w_same_cnt_d = '0;
            end else begin
              w_count_d = sat_step(r_count, CStep, w_dir);
            end
          end
        end
        StFine: begin
          w_count_d    = sat_step(r_count, FStep, w_dir);
          w_prev_dir_d = w_dir;
          w_prev_vld_d = 1'b1;
          if (w_rev) begin
            w_alt_cnt_d  = w_alt_inc;
            w_same_cnt_d = '0;
          end else begin
            w_same_cnt_d = w_same_inc;
            w_alt_cnt_d  = '0;
          end
          if (w_rev && w_alt_inc == 3'd4) begin
            w_state_d    = StLocked;
            w_div_cnt_d  = '0;
            w_alt_cnt_d  = '0;
            w_same_cnt_d = '0;
          end else if (!w_rev && w_same_inc == 3'd3) begin
            w_state_d    = StCoarse;
            w_prev_vld_d = 1'b0;
            w_alt_cnt_d  = '0;
            w_same_cnt_d = '0;
          end
        end
        StLocked: begin
          w_div_cnt_d = r_div_cnt + DW'(1);
          if (r_div_cnt == DivMax) begin
            w_count_d    = sat_step(r_count, FStep, w_dir);
            w_prev_dir_d = w_dir;
            w_prev_vld_d = 1'b1;
            // Run length of same-direction updates; a reversal starts a new run.
            w_same_cnt_d = w_rev ? 3'd1 : w_same_inc;
            if (!w_rev && w_same_inc == 3'd3) begin
              w_state_d    = StCoarse;
              w_prev_vld_d = 1'b0;
              w_same_cnt_d = '0;
              w_div_cnt_d  = '0;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    w_therm = '0;
    for (int i = 0; i < int'(N_CELLS); i++) begin
      w_therm[i] = (CW'(i) >= w_count_d);
    end
    w_gate_d = i_test_en ? i_test_code : w_therm;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_count    <= '0;
      r_gate     <= '1;
      r_comp_q   <= 1'b0;
      r_comp_vld <= 1'b0;
      r_div_cnt  <= '0;
      r_alt_cnt  <= '0;
      r_same_cnt <= '0;
      r_prev_dir <= 1'b0;
      r_prev_vld <= 1'b0;
      r_locked   <= 1'b0;
      r_sat_hi   <= 1'b0;
      r_sat_lo   <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_count    <= w_count_d;
      r_gate     <= w_gate_d;
      r_comp_q   <= i_comp_in;
      r_comp_vld <= w_comp_vld_d;
      r_div_cnt  <= w_div_cnt_d;
      r_alt_cnt  <= w_alt_cnt_d;
      r_same_cnt <= w_same_cnt_d;
      r_prev_dir <= w_prev_dir_d;
      r_prev_vld <= w_prev_vld_d;
      r_locked   <= (w_state_d == StLocked);
      r_sat_hi   <= (w_count_d == MaxCnt);
      r_sat_lo   <= (w_count_d == '0);
    end
  end

  assign o_gate   = r_gate;
  assign o_count  = r_count;
  assign o_locked = r_locked;
  assign o_sat_hi = r_sat_hi;
  assign o_sat_lo = r_sat_lo;

endmodule

// File: tb/tb_ldo_adaptive_ctrl.sv
// Directed bench for ldo_adaptive_ctrl with default parameters (32 cells, step 4, divide 8).
module tb_ldo_adaptive_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        comp_in;
  logic        test_en;
  logic [31:0] test_code;
  logic [31:0] gate;
  logic [5:0]  count;
  logic        locked;
  logic        sat_hi;
  logic        sat_lo;

  int total = 0;
  int bad   = 0;

  ldo_adaptive_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_comp_in   (comp_in),
    .i_test_en   (test_en),
    .i_test_code (test_code),
    .o_gate      (gate),
    .o_count     (count),
    .o_locked    (locked),
    .o_sat_hi    (sat_hi),
    .o_sat_lo    (sat_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Seven idle LOCKED cycles at hold_v, then the update edge.
  task automatic hold_then(input string tag, input int hold_v, input int new_v,
                           input logic new_lock);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk({tag, "_hold"}, 32'(count), 32'(hold_v));
      chk({tag, "_hold_lk"}, 32'(locked), 32'd1);
    end
    tick();
    chk({tag, "_upd"}, 32'(count), 32'(new_v));
    chk({tag, "_upd_lk"}, 32'(locked), 32'(new_lock));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; comp_in = 1'b0; test_en = 1'b0; test_code = '0;
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_gate", gate, 32'hFFFF_FFFF);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_sat_lo", 32'(sat_lo), 32'd1);
    chk("rst_sat_hi", 32'(sat_hi), 32'd0);

    // Ramp with comp_in held high.
    rst = 1'b0; en = 1'b1; comp_in = 1'b1;
    tick(); chk("ramp_e1", 32'(count), 32'd0);
    tick(); chk("ramp_e2", 32'(count), 32'd0);
    for (int k = 3; k <= 10; k++) begin
      tick();
      chk("ramp", 32'(count), 32'(4 * (k - 2)));
    end
    tick();
    tick();
    chk("top_count", 32'(count), 32'd32);
    chk("top_sat_hi", 32'(sat_hi), 32'd1);
    chk("top_sat_lo", 32'(sat_lo), 32'd0);
    chk("top_gate", gate, 32'h0000_0000);
    chk("top_locked", 32'(locked), 32'd0);

    rst = 1'b1;
    tick();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_gate", gate, 32'hFFFF_FFFF);
    chk("midrst_sat_hi", 32'(sat_hi), 32'd0);

    // Coarse to 16, then alternate into FINE and LOCKED.
    rst = 1'b0; comp_in = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    chk("b_e5", 32'(count), 32'd12);
    comp_in = 1'b0; tick(); chk("b_e6", 32'(count), 32'd16);
    comp_in = 1'b1; tick(); chk("b_e7", 32'(count), 32'd15);
    chk("b_e7_lk", 32'(locked), 32'd0);
    comp_in = 1'b0; tick(); chk("b_e8", 32'(count), 32'd16);
    comp_in = 1'b1; tick(); chk("b_e9", 32'(count), 32'd15);
    chk("b_e9_lk", 32'(locked), 32'd0);
    comp_in = 1'b0; tick(); chk("b_e10", 32'(count), 32'd16);
    chk("b_e10_lk", 32'(locked), 32'd1);

    // LOCKED: updates only every 8th edge.
    hold_then("lk_a", 16, 15, 1'b1);
    comp_in = 1'b1;
    hold_then("lk_b", 15, 16, 1'b1);
    comp_in = 1'b0;
    hold_then("lk_c", 16, 15, 1'b1);

    // Held low: third consecutive down update exits to COARSE.
    hold_then("dn_a", 15, 14, 1'b1);
    hold_then("dn_b", 14, 13, 1'b0);

    // Coarse descent with the gate override applied for two edges.
    test_en = 1'b1; test_code = 32'hA5A5_A5A5;
    tick(); chk("te_count1", 32'(count), 32'd9);
    chk("te_gate1", gate, 32'hA5A5_A5A5);
    tick(); chk("te_count2", 32'(count), 32'd5);
    chk("te_gate2", gate, 32'hA5A5_A5A5);
    test_en = 1'b0;
    tick(); chk("te_rel_count", 32'(count), 32'd1);
    chk("te_rel_gate", gate, 32'hFFFF_FFFE);
    tick(); chk("bot_count", 32'(count), 32'd0);
    chk("bot_sat_lo", 32'(sat_lo), 32'd1);
    chk("bot_gate", gate, 32'hFFFF_FFFF);
    tick(); chk("bot_hold", 32'(count), 32'd0);

    // Reach LOCKED at 20, then reset with enable and override active.
    rst = 1'b1; tick();
    rst = 1'b0; comp_in = 1'b1;
    for (int k = 1; k <= 6; k++) tick();
    comp_in = 1'b0; tick(); chk("r_e7", 32'(count), 32'd20);
    comp_in = 1'b1; tick(); chk("r_e8", 32'(count), 32'd19);
    comp_in = 1'b0; tick(); chk("r_e9", 32'(count), 32'd20);
    comp_in = 1'b1; tick(); chk("r_e10", 32'(count), 32'd19);
    tick(); chk("r_e11", 32'(count), 32'd20);
    chk("r_e11_lk", 32'(locked), 32'd1);
    rst = 1'b1; test_en = 1'b1; test_code = 32'hA5A5_A5A5;
    tick();
    chk("lkrst_count", 32'(count), 32'd0);
    chk("lkrst_gate", gate, 32'hFFFF_FFFF);
    chk("lkrst_locked", 32'(locked), 32'd0);
    chk("lkrst_sat_lo", 32'(sat_lo), 32'd1);

    // Restart from IDLE, then freeze with en=0 and resume.
    rst = 1'b0; test_en = 1'b0; comp_in = 1'b1;
    tick(); chk("rs_e1", 32'(count), 32'd0);
    tick(); chk("rs_e2", 32'(count), 32'd0);
    tick(); chk("rs_e3", 32'(count), 32'd4);
    en = 1'b0;
    tick(); chk("frz_e1", 32'(count), 32'd4);
    tick(); chk("frz_e2", 32'(count), 32'd4);
    chk("frz_gate", gate, 32'hFFFF_FFF0);
    en = 1'b1;
    tick(); chk("res_e1", 32'(count), 32'd4);
    tick(); chk("res_e2", 32'(count), 32'd4);
    tick(); chk("res_e3", 32'(count), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
